// File: rtl/serial_subtractor3_pkg.sv
// Shared definitions for the bit-serial two's-complement subtractor.
package serial_subtractor3_pkg;

  // Default operand/result width in bits.
  localparam int unsigned DefaultWidth = 3;

  // Control FSM encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFin   = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor3_if.sv
// Operand/result bundle between a requester (master) and the subtractor (slave).
interface serial_subtractor3_if
  import serial_subtractor3_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] DIFF;
  logic             OVF;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, A, B,
    input  DIFF, OVF, BUSY, DONE
  );

  modport slave (
    input  START, A, B,
    output DIFF, OVF, BUSY, DONE
  );

endinterface

// File: rtl/serial_subtractor3_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bout is the borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  // Difference and borrow for a single bit position.
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor3.sv
// Bit-serial signed subtractor: computes A-B one bit per cycle, LSB first,
// and presents a registered result with a signed-overflow flag.
module serial_subtractor3
  import serial_subtractor3_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 CLK,
  input  logic                 RST,
  serial_subtractor3_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  // Low for the first edge after reset release so a START seen there is ignored.
  logic              armed_q, armed_d;

  logic              bit_d;
  logic              bit_bout;
  logic              start_ok;

  full_subtractor u_full_subtractor (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (borrow_q),
    .D    (bit_d),
    .Bout (bit_bout)
  );

  // Next-state and registered-output computation for the control FSM.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    armed_d  = 1'b1;
    start_ok = bus.START && armed_q;

    case (state_q)
      StIdle, StFin: begin
        if (start_ok) begin
          a_d      = bus.A;
          b_d      = bus.B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = StShift;
          busy_d   = 1'b1;
        end else begin
          state_d  = StIdle;
          busy_d   = 1'b0;
        end
      end

      StShift: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = bit_bout;
        res_d    = {bit_d, res_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Last bit: a_q[0]/b_q[0] are now the operand sign bits.
          state_d  = StFin;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          diff_d   = res_d;
          ovf_d    = (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
          borrow_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      armed_q  <= armed_d;
    end
  end

  assign bus.DIFF = diff_q;
  assign bus.OVF  = ovf_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule
